// File: rtl/seg7_pkg.sv
// seg7_pkg
// Shared constants and types for the 4-digit common-anode 7-segment scanner.
//   - SEG_0..SEG_9 : active-low patterns, bit order {g,f,e,d,c,b,a}
//   - SEG_BLANK    : all segments off
//   - digit_pos_t  : digit position index (0 = rightmost)
//   - SEP_POS      : position whose decimal point acts as the hh:mm separator
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef logic [1:0] digit_pos_t;

    localparam digit_pos_t SEP_POS = 2'd2;

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode
// Combinational BCD to active-low 7-segment decoder. Codes 10..15 are not
// digits and simply produce a blank pattern.
// Ports:
//   bcd_i    in  4  BCD digit
//   seg_n_o  out 7  active-low segments {g,f,e,d,c,b,a}
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_n_o
);

    always_comb begin
        seg_n_o = SEG_BLANK;
        case (bcd_i)
            4'd0:    seg_n_o = SEG_0;
            4'd1:    seg_n_o = SEG_1;
            4'd2:    seg_n_o = SEG_2;
            4'd3:    seg_n_o = SEG_3;
            4'd4:    seg_n_o = SEG_4;
            4'd5:    seg_n_o = SEG_5;
            4'd6:    seg_n_o = SEG_6;
            4'd7:    seg_n_o = SEG_7;
            4'd8:    seg_n_o = SEG_8;
            4'd9:    seg_n_o = SEG_9;
            default: seg_n_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan.sv
// seg7_scan
// Time-multiplexed driver for a common-anode 4-digit 7-segment display.
// Each digit slot lasts SCAN_DIV cycles; the last cycle of every slot turns
// all anodes off so the segment lines can change without ghosting. Selected
// positions can blink with a half-period of BLINK_DIV full scan frames.
//
// Build option: SEG7_BLINK_EN -- when defined, the frame counter and blink
// phase exist and blink_mask is honoured; otherwise blink_mask is ignored.
//
// Parameters:
//   SCAN_DIV   clock cycles per digit slot including the guard cycle (>= 2)
//   BLINK_DIV  scan frames per blink half-period (>= 1)
// Ports:
//   clk         in  1  system clock
//   rst         in  1  asynchronous active-high reset
//   hh_t        in  4  BCD digit, position 3 (leftmost)
//   hh_u        in  4  BCD digit, position 2
//   mm_t        in  4  BCD digit, position 1
//   mm_u        in  4  BCD digit, position 0 (rightmost)
//   blink_mask  in  4  bit i blinks position i
//   seg_n       out 7  active-low segments {g,f,e,d,c,b,a}
//   dp_n        out 1  active-low decimal point (hh:mm separator)
//   an_n        out 4  active-low anodes, bit i selects position i
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] hh_t,
    input  logic [3:0] hh_u,
    input  logic [3:0] mm_t,
    input  logic [3:0] mm_u,
    input  logic [3:0] blink_mask,
    output logic [6:0] seg_n,
    output logic       dp_n,
    output logic [3:0] an_n
);

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    digit_pos_t    idx_q, idx_d;
    logic          tick;

    logic [3:0]    digit;
    logic [6:0]    dec_seg;
    logic          blanked;

    logic [6:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;
    logic          dp_q, dp_d;

    assign tick = (presc_q == PRESC_LAST);

    always_comb begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        idx_d   = tick ? idx_q + 2'd1 : idx_q;
    end

    always_comb begin
        digit = mm_u;
        case (idx_q)
            2'd0: digit = mm_u;
            2'd1: digit = mm_t;
            2'd2: digit = hh_u;
            2'd3: digit = hh_t;
            default: digit = mm_u;
        endcase
    end

    seg7_decode u_decode (
        .bcd_i   (digit),
        .seg_n_o (dec_seg)
    );

`ifdef SEG7_BLINK_EN
    localparam int FW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_DIV - 1);

    logic [FW-1:0] frame_q, frame_d;
    logic          phase_q, phase_d;

    // A frame ends on the tick that leaves position 3.
    always_comb begin
        frame_d = frame_q;
        phase_d = phase_q;
        if (tick && (idx_q == 2'd3)) begin
            if (frame_q == FRAME_LAST) begin
                frame_d = '0;
                phase_d = ~phase_q;
            end else begin
                frame_d = frame_q + FW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_q <= '0;
            phase_q <= 1'b0;
        end else begin
            frame_q <= frame_d;
            phase_q <= phase_d;
        end
    end

    assign blanked = phase_q & blink_mask[idx_q];
`else
    // Blinking compiled out: the mask is deliberately left dangling.
    logic unused_blink_mask;
    assign unused_blink_mask = ^blink_mask;
    assign blanked           = 1'b0;
`endif

    always_comb begin
        an_d  = tick ? 4'hF : ~(4'b0001 << idx_q);
        seg_d = blanked ? SEG_BLANK : dec_seg;
        dp_d  = ((idx_q == SEP_POS) && !blanked) ? 1'b0 : 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            idx_q   <= '0;
            seg_q   <= SEG_BLANK;
            an_q    <= 4'hF;
            dp_q    <= 1'b1;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            dp_q    <= dp_d;
        end
    end

    assign seg_n = seg_q;
    assign an_n  = an_q;
    assign dp_n  = dp_q;

endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan
// Directed bench for seg7_scan with SCAN_DIV = 4 and BLINK_DIV = 2. A model
// derived from the elapsed cycle count since reset release predicts every
// output cycle; a few literal expectations pin the model to known values.
module tb_seg7_scan;

    localparam int SD = 4;
    localparam int BD = 2;
`ifdef SEG7_BLINK_EN
    localparam bit BLINK_EN = 1'b1;
`else
    localparam bit BLINK_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [3:0] hh_t, hh_u, mm_t, mm_u, blink_mask;
    logic [6:0] seg_n;
    logic       dp_n;
    logic [3:0] an_n;

    int checks = 0;
    int errors = 0;

    seg7_scan #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
        .clk        (clk),
        .rst        (rst),
        .hh_t       (hh_t),
        .hh_u       (hh_u),
        .mm_t       (mm_t),
        .mm_u       (mm_u),
        .blink_mask (blink_mask),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .an_n       (an_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] pattern(input logic [3:0] d);
        logic [6:0] tbl [10];
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        if (d > 4'd9) return 7'h7F;
        return tbl[d];
    endfunction

    // Model: cycle c (edges since release, counted from 0) fully determines
    // slot position, guard cycle and blink phase.
    int         mc = 0;
    int         m_slot, m_pos, m_frame;
    bit         m_phase, m_blank;
    logic [3:0] m_dig;
    logic [6:0] e_seg;
    logic [3:0] e_an;
    logic       e_dp;

    always @(posedge clk) begin
        if (rst) begin
            mc    = 0;
            e_seg = 7'h7F;
            e_an  = 4'hF;
            e_dp  = 1'b1;
        end else begin
            m_slot  = mc % SD;
            m_pos   = (mc / SD) % 4;
            m_frame = mc / (4 * SD);
            m_phase = BLINK_EN && (((m_frame / BD) % 2) == 1);
            m_blank = m_phase && blink_mask[m_pos];
            case (m_pos)
                0: m_dig = mm_u;
                1: m_dig = mm_t;
                2: m_dig = hh_u;
                default: m_dig = hh_t;
            endcase
            e_an  = (m_slot == SD - 1) ? 4'hF : 4'hF ^ (4'b0001 << m_pos);
            e_seg = m_blank ? 7'h7F : pattern(m_dig);
            e_dp  = (m_pos == 2 && !m_blank) ? 1'b0 : 1'b1;
            mc++;
        end
        #1;
        chk("model_an", {3'b0, an_n}, {3'b0, e_an});
        chk("model_seg", seg_n, e_seg);
        chk("model_dp", {6'b0, dp_n}, {6'b0, e_dp});
    end

    task automatic set_digits(input logic [3:0] a, b, c, d);
        hh_t = a; hh_u = b; mm_t = c; mm_u = d;
    endtask

    task automatic lit(input string nm, input logic [3:0] an, input logic [6:0] seg, input logic dp);
        chk({nm, "_an"}, {3'b0, an_n}, {3'b0, an});
        chk({nm, "_seg"}, seg_n, seg);
        chk({nm, "_dp"}, {6'b0, dp_n}, {6'b0, dp});
    endtask

    initial begin
        rst = 1'b1;
        blink_mask = 4'b0000;
        set_digits(4'd1, 4'd2, 4'd3, 4'd4);
        repeat (3) @(negedge clk);
        lit("reset_hold", 4'hF, 7'h7F, 1'b1);

        rst = 1'b0;
        @(negedge clk);                       // after edge 1
        lit("first_edge", 4'b1110, 7'h19, 1'b1);
        repeat (3) @(negedge clk);            // edge 4: guard
        lit("guard0", 4'b1111, 7'h19, 1'b1);
        repeat (5) @(negedge clk);            // edge 9: position 2
        lit("pos2", 4'b1011, 7'h24, 1'b0);
        repeat (4) @(negedge clk);            // edge 13: position 3
        lit("pos3", 4'b0111, 7'h79, 1'b1);
        repeat (19) @(negedge clk);           // edge 32: frame boundary

        // Invalid code in position 0 only.
        set_digits(4'd1, 4'd2, 4'd3, 4'hC);
        @(negedge clk);
        lit("invalid", 4'b1110, 7'h7F, 1'b1);
        repeat (15) @(negedge clk);

        set_digits(4'd9, 4'd8, 4'd7, 4'd6);
        repeat (16) @(negedge clk);
        set_digits(4'd0, 4'd5, 4'd0, 4'd5);
        repeat (16) @(negedge clk);
        set_digits(4'd2, 4'd3, 4'd5, 4'd9);
        repeat (16) @(negedge clk);

        // Blink over eight frames.
        blink_mask = 4'b1100;
        repeat (128) @(negedge clk);

        // Asynchronous reset in the middle of a position-2 slot.
        repeat (9) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 lit("async_rst", 4'hF, 7'h7F, 1'b1);
        set_digits(4'd1, 4'd2, 4'd3, 4'd4);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        @(negedge clk);                       // edge 1
        lit("restart", 4'b1110, 7'h19, 1'b1);
        repeat (8) @(negedge clk);            // edge 9: frame 0
        lit("restart_pos2", 4'b1011, 7'h24, 1'b0);
        repeat (24) @(negedge clk);           // edge 33: frame 2, position 0
        lit("blink_pos0", 4'b1110, 7'h19, 1'b1);
        repeat (8) @(negedge clk);            // edge 41: frame 2, position 2
        if (BLINK_EN) lit("blink_pos2", 4'b1011, 7'h7F, 1'b1);
        else          lit("blink_pos2", 4'b1011, 7'h24, 1'b0);

        blink_mask = 4'hF;
        repeat (128) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
